// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and helper functions for uart_core.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clocks per baud tick, truncated and never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 32'sd1) ? 32'sd1 : div;
    endfunction

    // Parity over a zero-extended payload; odd=1 inverts the even result.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: host-side byte interface of uart_core (transmit handshake and receive report).
interface uart_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_done;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, rx_valid, rx_data, rx_frame_err, rx_parity_err
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, rx_valid, rx_data, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-clk tick every DIV clocks.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Wrap the count at DIV-1; the tick flop is high while the count sits at DIV-1.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = CNT_W'(0);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == LAST);
    end

    // Divider state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= CNT_W'(0);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART, one transmitter and one oversampling receiver
// sharing a baud tick. Define UART_PARITY_EN to add a parity bit to every frame.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic  clk,
    input  logic  rst,
    uart_if.slave bus,
    output logic  tx,
    input  logic  rx
);
    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CNT_W = $clog2(OVERSAMPLE * STOP_BITS);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(OVERSAMPLE * STOP_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 8) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
        $error("uart_core: illegal parameter combination");
    end

    logic tick_s;
    uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .tick(tick_s));

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_launch_q, tx_launch_d;   // start bit is on the line
    logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_done_q, tx_done_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    // TX state register; reset parks the line high and the FSM idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= CNT_W'(0);
            tx_bit_q    <= BIT_W'(0);
            tx_shift_q  <= {DATA_BITS{1'b0}};
            tx_launch_q <= 1'b0;
            tx_q        <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q    <= 1'b0;
`endif
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_launch_q <= tx_launch_d;
            tx_q        <= tx_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
`ifdef UART_PARITY_EN
            tx_par_q    <= tx_par_d;
`endif
        end
    end

    // TX next state: latch on handshake, launch on the next tick, hold each bit OVERSAMPLE ticks.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_launch_d = tx_launch_q;
`ifdef UART_PARITY_EN
        tx_par_d    = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_valid && tx_ready_q) begin
                    tx_state_d  = TX_START;
                    tx_shift_d  = bus.tx_data;
                    tx_launch_d = 1'b0;
                    tx_cnt_d    = CNT_W'(0);
                    tx_bit_d    = BIT_W'(0);
`ifdef UART_PARITY_EN
                    tx_par_d    = calc_parity(MAX_DATA_BITS'(bus.tx_data), (PARITY_ODD != 0));
`endif
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (!tick_s) begin
                    tx_state_d = TX_START;
                end else if (!tx_launch_q) begin
                    tx_launch_d = 1'b1;
                    tx_cnt_d    = CNT_W'(0);
                end else if (tx_cnt_q == OS_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_W'(0);
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (!tick_s) begin
                    tx_state_d = TX_DATA;
                end else if (tx_cnt_q != OS_LAST) begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end else if (tx_bit_q == BIT_LAST) begin
                    tx_cnt_d = CNT_W'(0);
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
`else
                    tx_state_d = TX_STOP;
`endif
                end else begin
                    tx_cnt_d   = CNT_W'(0);
                    tx_bit_d   = tx_bit_q + BIT_W'(1);
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (!tick_s) begin
                    tx_state_d = TX_PARITY;
                end else if (tx_cnt_q == OS_LAST) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = CNT_W'(0);
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`endif
            TX_STOP: begin
                if (!tick_s) begin
                    tx_state_d = TX_STOP;
                end else if (tx_cnt_q == STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = CNT_W'(0);
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: line level follows the upcoming state so every output is a flop.
    always_comb begin
        tx_ready_d = (tx_state_d == TX_IDLE);
        tx_done_d  = (tx_state_q == TX_STOP) && tick_s && (tx_cnt_q == STOP_LAST);
        case (tx_state_d)
            TX_IDLE:   tx_d = 1'b1;
            TX_START:  tx_d = ~tx_launch_d;
            TX_DATA:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par_d;
`endif
            TX_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_valid_q, rx_valid_d, rx_frame_err_q, rx_frame_err_d;
    logic                 rx_fall_s, rx_sample_s;
`ifdef UART_PARITY_EN
    logic                 rx_par_bit_q, rx_par_bit_d, rx_parity_err_q, rx_parity_err_d;
`endif

    assign rx_fall_s   = rx_prev_q & ~rx_s2_q;
    assign rx_sample_s = tick_s && (rx_cnt_q == OS_LAST);

    // RX synchronizer and state register; the synchronizer resets to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= CNT_W'(0);
            rx_bit_q       <= BIT_W'(0);
            rx_shift_q     <= {DATA_BITS{1'b0}};
            rx_valid_q     <= 1'b0;
            rx_data_q      <= {DATA_BITS{1'b0}};
            rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit_q    <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q        <= rx;
            rx_s2_q        <= rx_s1_q;
            rx_prev_q      <= rx_s2_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            rx_frame_err_q <= rx_frame_err_d;
`ifdef UART_PARITY_EN
            rx_par_bit_q    <= rx_par_bit_d;
            rx_parity_err_q <= rx_parity_err_d;
`endif
        end
    end

    // RX next state: verify the start bit at half a bit, then sample every bit at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
`ifdef UART_PARITY_EN
        rx_par_bit_d = rx_par_bit_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_W'(0);
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (!tick_s) begin
                    rx_state_d = RX_START;
                end else if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = CNT_W'(0);
                    rx_bit_d   = BIT_W'(0);
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (!tick_s) begin
                    rx_state_d = RX_DATA;
                end else if (rx_cnt_q != OS_LAST) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end else begin
                    rx_cnt_d   = CNT_W'(0);
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BIT_W'(1);
                    if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_sample_s) begin
                    rx_cnt_d     = CNT_W'(0);
                    rx_par_bit_d = rx_s2_q;
                    rx_state_d   = RX_STOP;
                end else if (tick_s) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end else begin
                    rx_state_d = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (rx_sample_s) begin
                    rx_cnt_d   = CNT_W'(0);
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
                end else if (tick_s) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: report the frame at the stop-bit sample and hold it until the next one.
    always_comb begin
        rx_valid_d = (rx_state_q == RX_STOP) && rx_sample_s;
        if (rx_valid_d) begin
            rx_data_d      = rx_shift_q;
            rx_frame_err_d = ~rx_s2_q;
        end else begin
            rx_data_d      = rx_data_q;
            rx_frame_err_d = rx_frame_err_q;
        end
`ifdef UART_PARITY_EN
        if (rx_valid_d) begin
            rx_parity_err_d = rx_par_bit_q ^ calc_parity(MAX_DATA_BITS'(rx_shift_q), (PARITY_ODD != 0));
        end else begin
            rx_parity_err_d = rx_parity_err_q;
        end
`endif
    end

    assign tx                = tx_q;
    assign bus.tx_ready      = tx_ready_q;
    assign bus.tx_done       = tx_done_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_frame_err  = rx_frame_err_q;
`ifdef UART_PARITY_EN
    assign bus.rx_parity_err = rx_parity_err_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed + randomized bench for uart_core at 1.6 MHz / 10 kbaud / x16
// (10 clk per tick, 160 clk per bit). Expected frames come from a bit-list model.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CLK_FREQ   = 1600000;
    localparam int BAUD_RATE  = 10000;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int OVERSAMPLE = 16;
    localparam int PARITY_ODD = 0;
    localparam int DIV_CLK    = 10;
    localparam int BIT_CLK    = 160;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drive = 1'b1;
    logic loopback = 1'b0;
    logic tx_pin;
    logic rx_pin;
    assign rx_pin = loopback ? tx_pin : rx_drive;

    uart_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_core #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS), .OVERSAMPLE(OVERSAMPLE), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .tx(tx_pin), .rx(rx_pin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] rxd_q[$];
    logic       rxf_q[$];
    logic       rxp_q[$];
    logic [7:0] exp_q[$];
    logic       fb[0:15];
    int         flen;

    // Monitor: count tx_done pulses and record every received frame.
    always @(negedge clk) begin
        if (bus.tx_done === 1'b1) done_cnt++;
        if (bus.rx_valid === 1'b1) begin
            rxd_q.push_back(bus.rx_data);
            rxf_q.push_back(bus.rx_frame_err);
            rxp_q.push_back(bus.rx_parity_err);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity (flippable), stop bits.
    task automatic build_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
        int ones;
        ones = 0;
        flen = 0;
        fb[flen] = 1'b0; flen++;
        for (int i = 0; i < DATA_BITS; i++) begin
            fb[flen] = d[i]; flen++;
            ones += int'(d[i]);
        end
        if (PAR_BITS == 1) begin
            fb[flen] = 1'((ones % 2) + PARITY_ODD) ^ par_flip; flen++;
        end
        for (int i = 0; i < STOP_BITS; i++) begin
            fb[flen] = stop_val; flen++;
        end
    endtask

    task automatic drive_frame();
        for (int i = 0; i < flen; i++) begin
            rx_drive = fb[i];
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    // Present a byte and return on the negedge after it is accepted.
    task automatic send(input logic [7:0] d);
        int n;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(n < 4000), 32'd1);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Follow one transmitted frame bit by bit against the model.
    task automatic check_tx_frame(input logic [7:0] d);
        int n;
        int t;
        int done0;
        done0 = done_cnt;
        check("tx_ready_fell", 32'(bus.tx_ready), 32'd0);
        n = 0;
        while (tx_pin !== 1'b0 && n < 4 * DIV_CLK) begin
            @(negedge clk);
            n++;
        end
        check("tx_launch_delay", 32'(n >= 1 && n <= DIV_CLK), 32'd1);
        build_frame(d, 1'b1, 1'b0);
        t = 0;
        for (int k = 0; k < flen; k++) begin
            while (t < BIT_CLK / 2 + BIT_CLK * k) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("tx_bit%0d", k), 32'(tx_pin), 32'(fb[k]));
            check($sformatf("tx_busy%0d", k), 32'(bus.tx_ready), 32'd0);
        end
        while (bus.tx_done !== 1'b1 && t < flen * BIT_CLK + 50) begin
            @(negedge clk);
            t++;
        end
        check("tx_frame_len", 32'(t), 32'(flen * BIT_CLK));
        check("tx_ready_at_done", 32'(bus.tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("tx_done_once", 32'(done_cnt - done0), 32'd1);
    endtask

    task automatic wait_rx(input int target, input int limit);
        int k;
        k = 0;
        while (rxd_q.size() < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("rx_wait", 32'(rxd_q.size() >= target), 32'd1);
    endtask

    task automatic check_rx(input int idx, input logic [7:0] d, input logic f, input logic p);
        if (idx < rxd_q.size()) begin
            check("rx_data", 32'(rxd_q[idx]), 32'(d));
            check("rx_frame_err", 32'(rxf_q[idx]), 32'(f));
            check("rx_parity_err", 32'(rxp_q[idx]), 32'(p));
        end else begin
            check("rx_present", 32'(rxd_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int base;
        int n;
        int done0;
        logic [7:0] d;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_tx", 32'(tx_pin), 32'd1);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_tx_done", 32'(bus.tx_done), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_rx_ferr", 32'(bus.rx_frame_err), 32'd0);
        check("rst_rx_perr", 32'(bus.rx_parity_err), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // TX waveform for 0xA5 and for one random byte
        send(8'hA5);
        check_tx_frame(8'hA5);
        d = 8'($urandom);
        send(d);
        check_tx_frame(d);

        // Loopback: 0x3C, 0xC3 and three random bytes back-to-back
        loopback = 1'b1;
        repeat (40) @(negedge clk);
        base  = rxd_q.size();
        done0 = done_cnt;
        exp_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) send(exp_q[i]);
        wait_rx(base + 5, 4000);
        for (int i = 0; i < 5; i++) check_rx(base + i, exp_q[i], 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("loop_done_cnt", 32'(done_cnt - done0), 32'd5);
        loopback = 1'b0;
        repeat (40) @(negedge clk);

        // False start: 40 clk low pulse
        base = rxd_q.size();
        rx_drive = 1'b0;
        repeat (40) @(negedge clk);
        rx_drive = 1'b1;
        repeat (400) @(negedge clk);
        check("false_start_silent", 32'(rxd_q.size()), 32'(base));
        d = 8'($urandom);
        build_frame(d, 1'b1, 1'b0);
        drive_frame();
        wait_rx(base + 1, 400);
        check_rx(base, d, 1'b0, 1'b0);

        // Framing error: 0x55 with low stop bit, then a 2-bit-time break
        repeat (BIT_CLK) @(negedge clk);
        base = rxd_q.size();
        build_frame(8'h55, 1'b0, 1'b0);
        drive_frame();
        repeat (2 * BIT_CLK) @(negedge clk);
        check("ferr_count", 32'(rxd_q.size()), 32'(base + 1));
        check_rx(base, 8'h55, 1'b1, 1'b0);
        check("ferr_hold_data", 32'(bus.rx_data), 32'h55);
        check("ferr_hold_flag", 32'(bus.rx_frame_err), 32'd1);
        rx_drive = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("break_silent", 32'(rxd_q.size()), 32'(base + 1));
        d = 8'($urandom);
        build_frame(d, 1'b1, 1'b0);
        drive_frame();
        wait_rx(base + 2, 400);
        check_rx(base + 1, d, 1'b0, 1'b0);

        // Random injected frames
        for (int i = 0; i < 3; i++) begin
            repeat (int'($urandom_range(20, 200))) @(negedge clk);
            base = rxd_q.size();
            d = 8'($urandom);
            build_frame(d, 1'b1, 1'b0);
            drive_frame();
            wait_rx(base + 1, 400);
            check_rx(base, d, 1'b0, 1'b0);
        end

`ifdef UART_PARITY_EN
        // Parity: 0x07 carrying parity bit 0 under even parity
        repeat (BIT_CLK) @(negedge clk);
        base = rxd_q.size();
        build_frame(8'h07, 1'b1, 1'b1);
        drive_frame();
        wait_rx(base + 1, 400);
        check_rx(base, 8'h07, 1'b0, 1'b1);
`endif

        // Reset in the middle of TX data bits (RX looped back, also mid-frame)
        loopback = 1'b1;
        repeat (40) @(negedge clk);
        base = rxd_q.size();
        d = 8'($urandom);
        send(d);
        n = 0;
        while (tx_pin !== 1'b0 && n < 4 * DIV_CLK) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        done0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx_high", 32'(tx_pin), 32'd1);
        check("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("abort_tx_done", 32'(bus.tx_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(done0));
        check("abort_no_rx", 32'(rxd_q.size()), 32'(base));

        // Recovery after reset
        d = 8'($urandom);
        send(d);
        wait_rx(base + 1, 4000);
        check_rx(base, d, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART engine: one transmitter and one oversampling receiver sharing a single baud-tick generator. It succeeds the fixed 8N1 tx/rx pair with configurable frame width, stop bits and oversampling, plus a ready/valid transmit handshake, glitch-rejecting start detection and framing-error reporting. Optional parity is available at compile time. It sits between the host-side byte interface and the serial pins.

## Interface
- CLK_FREQ, 1000000: clk frequency in Hz.
- BAUD_RATE, 9600: serial bit rate.
- DATA_BITS, 8: payload bits per frame, legal values 5..8.
- STOP_BITS, 1: stop bits sent by TX, 1 or 2. RX checks only the first.
- OVERSAMPLE, 16: baud ticks per bit. Must be even and at least 8.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Used only when UART_PARITY_EN is defined.
- clk  in  1  system clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  host presents tx_data.
- tx_data  in  DATA_BITS  byte to send.
- tx_ready  out  1  TX idle and able to accept.
- tx_done  out  1  one-cycle pulse when the last stop bit ends.
- tx  out  1  serial output, idles high.
- rx  in  1  serial input, asynchronous.
- rx_valid  out  1  one-cycle pulse, rx_data is valid.
- rx_data  out  DATA_BITS  received payload, LSB first on the line.
- rx_frame_err  out  1  qualifies rx_valid: the stop bit was sampled low.
- rx_parity_err  out  1  qualifies rx_valid: parity mismatch. Tied 0 when parity is compiled out.

## Operation
- Baud tick: free-running counter, DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) with integer truncation, clamped to a minimum of 1. It emits a one-clk tick when the count reaches DIV-1, then wraps to 0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Transfer occurs on a cycle with tx_valid && tx_ready. tx_data is latched that cycle.
  - Each bit is held for OVERSAMPLE ticks.
  - Data bits go out LSB first.
  - STOP lasts STOP_BITS bit periods. STOP returns to IDLE.
  - The PARITY state is skipped when parity is compiled out.
- RX path: rx passes through a 2-flop synchronizer. All decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - In IDLE, a high-to-low transition on the synchronized rx starts a frame; the tick counter restarts.
  - Start bit is sampled at tick OVERSAMPLE/2. If it is high, the frame is a false start and the FSM returns to IDLE with no output.
  - Each later bit is sampled OVERSAMPLE ticks after the previous sample point (mid-bit).
  - Stop bit sampled high: pulse rx_valid and go to IDLE.
  - Stop bit sampled low: pulse rx_valid with rx_frame_err=1, then go to WAIT_HIGH. WAIT_HIGH stays until rx is high (break condition), then goes to IDLE.
- rx_data, rx_frame_err and rx_parity_err update only in the cycle that rx_valid pulses, and hold their values until the next rx_valid.
- TX and RX are fully independent. Simultaneous activity has no interaction.

## Timing
- Reset values: tx=1, tx_ready=1, tx_done=0, rx_valid=0, rx_data=0, rx_frame_err=0, rx_parity_err=0. Both FSMs go to IDLE and the tick counter goes to 0.
- tx_ready falls on the clk after acceptance.
- The start bit drives tx low on the first baud tick after acceptance, giving at most DIV clk of launch jitter.
- tx_done pulses and tx_ready rises in the same clk, at the end of the final stop period. A new transfer may be accepted in that same cycle, giving back-to-back frames with no idle gap.
- tx_valid while tx_ready=0 is ignored. tx_data is don't-care when not transferring.
- RX latency: rx_valid occurs 2 clk (synchronizer) plus the stop-bit mid-sample point after the start edge.
- rst asserted mid-frame aborts both paths on the next edge. tx returns high immediately, and no rx_valid or tx_done is produced for the aborted frames.

## Configuration
- UART_PARITY_EN defined:
  - TX inserts a parity bit after the data bits: the XOR of the data bits, inverted when PARITY_ODD=1.
  - RX checks parity and sets rx_parity_err on a mismatch.
  - Frame length is 1+DATA_BITS+1+STOP_BITS bits.
- UART_PARITY_EN undefined:
  - No parity bit is sent or expected, and the PARITY states are absent.
  - rx_parity_err is tied to 0 and PARITY_ODD is ignored.

## Structure
- uart_pkg holds:
  - the tx_state_t and rx_state_t enums;
  - a function computing DIV, with the clamp;
  - a function computing parity.
- One sub-module, uart_baud_gen: the parameterised tick generator instantiated once inside uart_core.
- The TX and RX FSMs live in uart_core as separate always_ff blocks.

## Test plan
All scenarios use CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and one bit is 160 clk.
- Send 0xA5 at 8N1 -> tx shows 0,1,0,1,0,0,1,0,1,1, each bit 160 clk. tx_done pulses once, and tx_ready is low for the whole frame.
- Loop tx back to rx, send 0x3C then 0xC3 back-to-back -> two rx_valid pulses with rx_data 0x3C then 0xC3, both with rx_frame_err=0.
- Drive rx low for 40 clk, then high -> no rx_valid, and RX is back in IDLE (false start).
- Drive a 0x55 frame with the stop bit low, then hold rx low for 2 bit times -> one rx_valid with rx_data=0x55 and rx_frame_err=1. No further frame until rx returns high.
- With UART_PARITY_EN and PARITY_ODD=0, inject 0x07 carrying parity bit 0 -> rx_valid with rx_parity_err=1.
- Assert rst in the middle of the DATA bits of a TX frame -> tx=1 and tx_ready=1 on the next clk, with no tx_done pulse.
